vending_scheduler: RTL and testbench

Front-end controller for a single `Vending` machine instance. It collects the machine's six configuration bytes over a valid/ready port, then resets the machine and streams those bytes into it on six consecutive cycles. After that it shares the machine between `NK` customer kiosks. Kiosks are served one session at a time in round-robin order, and results are routed back to the kiosk that owns the session.

---
 rtl/vending_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_vending_scheduler.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_scheduler.sv
// vending_scheduler: configures one Vending machine, then time-shares it
// between NK kiosks, one session at a time, in round-robin order.
module vending_scheduler #(
   parameter int NK      = 2,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_valid,
   input  logic [7:0]      cfg_data,
   output logic            cfg_ready,
   input  logic [NK-1:0]   req,
   input  logic [8*NK-1:0] k_mi,
   input  logic [2*NK-1:0] k_sel,
   input  logic [NK-1:0]   k_re,
   output logic [NK-1:0]   gnt,
   output logic [NK-1:0]   k_done,
   output logic [7:0]      k_mo,
   output logic [1:0]      k_po,
   output logic            run,
   output logic            v_rst,
   output logic [7:0]      v_di,
   output logic [7:0]      v_mi,
   output logic [1:0]      v_sel,
   output logic            v_re,
   input  logic [7:0]      v_mo,
   input  logic [1:0]      v_po,
   input  logic            v_empty
);

   localparam int PW = (NK > 1) ? $clog2(NK) : 1;
   localparam int IW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      CFG, LOAD_RST, LOAD, ARB, SERVE, SETTLE
   } state_t;

   state_t        state, state_n;
   logic [2:0]    idx;
   logic [7:0]    cfg_buf [6];
   logic [PW-1:0] ptr, pick, cand, gidx;
   logic [IW-1:0] idle;
   logic          end_req;
   logic          any_req;
   logic [7:0]    s_mi;
   logic [1:0]    s_sel;
   logic          s_re, s_req;
   logic          act, stop, forced, done;

   // round-robin pick: first requester at or after ptr
   always_comb begin
      pick    = ptr;
      cand    = ptr;
      any_req = 1'b0;
      for (int i = 0; i < NK; i++) begin
         cand = PW'((int'(ptr) + i) % NK);
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            pick    = cand;
         end
      end
   end

   // select the owning kiosk's inputs from the one-hot grant
   always_comb begin
      gidx  = '0;
      s_mi  = '0;
      s_sel = '0;
      s_re  = 1'b0;
      s_req = 1'b0;
      for (int i = 0; i < NK; i++) begin
         if (gnt[i]) begin
            gidx  = PW'(i);
            s_mi  = k_mi[8*i +: 8];
            s_sel = k_sel[2*i +: 2];
            s_re  = k_re[i];
            s_req = req[i];
         end
      end
   end

   assign act    = (s_mi != 8'd0) | (s_sel != 2'd0) | s_re;
   assign stop   = (s_sel != 2'd0) | s_re;
   assign forced = !s_req | (idle == IW'(TIMEOUT));
   assign done   = (v_po != 2'd0) | v_empty | end_req;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= CFG;
      else     state <= state_n;
   end

   // next-state logic
   always_comb begin
      state_n = state;
      unique case (state)
         CFG:      if (cfg_valid && idx == 3'd5) state_n = LOAD_RST;
         LOAD_RST: state_n = LOAD;
         LOAD:     if (idx == 3'd5) state_n = ARB;
         ARB:      if (any_req) state_n = SERVE;
         SERVE:    if (forced || stop) state_n = SETTLE;
         SETTLE:   state_n = done ? ARB : SERVE;
         default:  state_n = CFG;
      endcase
   end

   // outputs decoded from state; forced refund masks kiosk inputs
   always_comb begin
      cfg_ready = (state == CFG);
      v_di      = '0;
      v_mi      = '0;
      v_sel     = '0;
      v_re      = 1'b0;
      if (state == LOAD) v_di = cfg_buf[idx];
      if (state == SERVE) begin
         if (forced) begin
            v_re = 1'b1;
         end else begin
            v_mi  = s_mi;
            v_sel = s_sel;
            v_re  = s_re;
         end
      end
   end

   // config buffer, session bookkeeping and registered results
   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         cfg_buf <= '{default: 8'd0};
         ptr     <= '0;
         idle    <= '0;
         end_req <= 1'b0;
         gnt     <= '0;
         k_done  <= '0;
         k_mo    <= '0;
         k_po    <= '0;
         run     <= 1'b0;
         v_rst   <= 1'b1;
      end else begin
         k_done <= '0;
         v_rst  <= (state_n == CFG) || (state_n == LOAD_RST);
         unique case (state)
            CFG: begin
               if (cfg_valid) begin
                  cfg_buf[idx] <= cfg_data;
                  idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
               end
            end
            LOAD_RST: idx <= '0;
            LOAD: begin
               idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
               if (idx == 3'd5) run <= 1'b1;
            end
            ARB: begin
               if (any_req) begin
                  gnt  <= NK'(1) << pick;
                  idle <= '0;
               end
            end
            SERVE: begin
               if (act) idle <= '0;
               else if (idle != IW'(TIMEOUT)) idle <= idle + 1'b1;
               if (forced) end_req <= 1'b1;
               else if (stop) end_req <= s_re;
            end
            SETTLE: begin
               if (done) begin
                  k_mo   <= v_mo;
                  k_po   <= v_po;
                  k_done <= gnt;
                  gnt    <= '0;
                  ptr    <= (int'(gidx) == NK - 1) ? '0 : gidx + 1'b1;
               end else begin
                  idle <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vending_scheduler.sv
// tb_vending_scheduler: directed tests of vending_scheduler against a
// small behavioural Vending machine model.
module tb_vending_scheduler;

   localparam int NK = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            cfg_valid;
   logic [7:0]      cfg_data;
   logic            cfg_ready;
   logic [NK-1:0]   req;
   logic [8*NK-1:0] k_mi;
   logic [2*NK-1:0] k_sel;
   logic [NK-1:0]   k_re;
   logic [NK-1:0]   gnt;
   logic [NK-1:0]   k_done;
   logic [7:0]      k_mo;
   logic [1:0]      k_po;
   logic            run;
   logic            v_rst;
   logic [7:0]      v_di;
   logic [7:0]      v_mi;
   logic [1:0]      v_sel;
   logic            v_re;
   logic [7:0]      v_mo;
   logic [1:0]      v_po;
   logic            v_empty;

   int checks = 0;
   int errors = 0;
   logic [7:0] cfgv [6] = '{8'd10, 8'd2, 8'd20, 8'd1, 8'd30, 8'd0};

   vending_scheduler #(.NK(NK), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .req(req), .k_mi(k_mi), .k_sel(k_sel), .k_re(k_re),
      .gnt(gnt), .k_done(k_done), .k_mo(k_mo), .k_po(k_po),
      .run(run), .v_rst(v_rst), .v_di(v_di),
      .v_mi(v_mi), .v_sel(v_sel), .v_re(v_re),
      .v_mo(v_mo), .v_po(v_po), .v_empty(v_empty)
   );

   always #5 clk = ~clk;

   // behavioural Vending: loads 6 bytes after reset, then vends/refunds
   logic [7:0] vcfg [6];
   int         vcnt = 0;
   logic [7:0] credit, tot, price;
   logic [2:0] qi;
   logic       can_buy;

   always_comb begin
      tot     = credit + v_mi;
      qi      = 3'd1;
      price   = 8'd0;
      can_buy = 1'b0;
      if (v_sel != 2'd0) begin
         qi      = {v_sel, 1'b0} - 3'd1;
         price   = vcfg[qi - 3'd1];
         can_buy = (vcfg[qi] != 8'd0) && (tot >= price);
      end
   end

   assign v_empty = (vcnt == 6) && (vcfg[1] == 0) &&
                    (vcfg[3] == 0) && (vcfg[5] == 0);

   always @(posedge clk) begin
      v_mo <= 8'd0;
      v_po <= 2'd0;
      if (v_rst === 1'b1) begin
         vcnt   <= 0;
         credit <= 8'd0;
      end else if (vcnt < 6) begin
         vcfg[vcnt] <= v_di;
         vcnt       <= vcnt + 1;
      end else if (can_buy) begin
         v_po     <= v_sel;
         v_mo     <= tot - price;
         credit   <= 8'd0;
         vcfg[qi] <= vcfg[qi] - 8'd1;
      end else if (v_re) begin
         v_mo   <= tot;
         credit <= 8'd0;
      end else begin
         credit <= tot;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      cfg_valid = 1'b0;
      cfg_data  = 8'd0;
      req       = '0;
      k_mi      = '0;
      k_sel     = '0;
      k_re      = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_gnt(output int n);
      tick();
      n = 1;
      while (gnt === '0 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_done(output int n);
      tick();
      n = 1;
      while (k_done === '0 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic session(input int k, input logic [7:0] mi,
                          input logic [1:0] sel, output logic bad);
      int n1, n2;
      req = NK'(1) << k;
      wait_gnt(n1);
      k_mi[8*k +: 8]  = mi;
      k_sel[2*k +: 2] = sel;
      tick();
      k_mi  = '0;
      k_sel = '0;
      req   = '0;
      wait_done(n2);
      bad = (n1 >= 20) || (n2 >= 20);
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (gnt !== 2'b00 || k_done !== 2'b00) begin
         errors++;
         $display("FAIL reset_gnt: gnt=%b k_done=%b want 00 00", gnt, k_done);
      end
      checks++;
      if (k_mo !== 8'd0 || k_po !== 2'd0 || run !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: k_mo=%0d k_po=%0d run=%b want 0 0 0",
                  k_mo, k_po, run);
      end
      checks++;
      if (v_rst !== 1'b1 || cfg_ready !== 1'b1 || v_di !== 8'd0) begin
         errors++;
         $display("FAIL reset_vrst: v_rst=%b cfg_ready=%b v_di=%0d want 1 1 0",
                  v_rst, cfg_ready, v_di);
      end
      rst = 1'b0;
   endtask

   task automatic test_config();
      for (int b = 0; b < 6; b++) begin
         if (b == 3) begin
            cfg_valid = 1'b0;
            tick();
            tick();
            checks++;
            if (cfg_ready !== 1'b1 || v_rst !== 1'b1) begin
               errors++;
               $display("FAIL cfg_gap: cfg_ready=%b v_rst=%b want 1 1",
                        cfg_ready, v_rst);
            end
         end
         cfg_valid = 1'b1;
         cfg_data  = cfgv[b];
         tick();
      end
      cfg_valid = 1'b0;
      cfg_data  = 8'd0;
      checks++;
      if (v_rst !== 1'b1 || cfg_ready !== 1'b0 || run !== 1'b0) begin
         errors++;
         $display("FAIL cfg_ldrst: v_rst=%b cfg_ready=%b run=%b want 1 0 0",
                  v_rst, cfg_ready, run);
      end
      for (int b = 0; b < 6; b++) begin
         tick();
         checks++;
         if (v_di !== cfgv[b] || v_rst !== 1'b0) begin
            errors++;
            $display("FAIL cfg_load%0d: v_di=%0d v_rst=%b want %0d 0",
                     b, v_di, v_rst, cfgv[b]);
         end
      end
      tick();
      checks++;
      if (run !== 1'b1 || v_di !== 8'd0) begin
         errors++;
         $display("FAIL cfg_run: run=%b v_di=%0d want 1 0", run, v_di);
      end
   endtask

   task automatic test_purchase();
      int n;
      req = 2'b01;
      wait_gnt(n);
      checks++;
      if (n != 1 || gnt !== 2'b01) begin
         errors++;
         $display("FAIL buy_gnt: gnt=%b after %0d cycles want 01 after 1", gnt, n);
      end
      k_mi[7:0]  = 8'd25;
      k_sel[1:0] = 2'd1;
      #1;
      checks++;
      if (v_mi !== 8'd25 || v_sel !== 2'd1 || v_re !== 1'b0) begin
         errors++;
         $display("FAIL buy_fwd: v_mi=%0d v_sel=%0d v_re=%b want 25 1 0",
                  v_mi, v_sel, v_re);
      end
      tick();
      k_mi  = '0;
      k_sel = '0;
      req   = '0;
      checks++;
      if (gnt !== 2'b01 || k_done !== 2'b00 || v_sel !== 2'd0) begin
         errors++;
         $display("FAIL buy_settle: gnt=%b k_done=%b v_sel=%0d want 01 00 0",
                  gnt, k_done, v_sel);
      end
      tick();
      checks++;
      if (k_done !== 2'b01 || k_po !== 2'd1 || k_mo !== 8'd15 || gnt !== 2'b00) begin
         errors++;
         $display("FAIL buy_done: k_done=%b k_po=%0d k_mo=%0d gnt=%b want 01 1 15 00",
                  k_done, k_po, k_mo, gnt);
      end
      tick();
      checks++;
      if (k_done !== 2'b00 || k_mo !== 8'd15 || k_po !== 2'd1) begin
         errors++;
         $display("FAIL buy_hold: k_done=%b k_mo=%0d k_po=%0d want 00 15 1",
                  k_done, k_mo, k_po);
      end
   endtask

   task automatic test_round_robin();
      int n;
      logic [NK-1:0] exp;
      req = 2'b01;
      wait_gnt(n);
      checks++;
      if (n != 1 || gnt !== 2'b01) begin
         errors++;
         $display("FAIL rr_first: gnt=%b n=%0d want 01 1", gnt, n);
      end
      req        = 2'b11;
      k_mi[15:8] = 8'd99;
      k_re       = 2'b01;
      #1;
      checks++;
      if (v_re !== 1'b1 || v_mi !== 8'd0) begin
         errors++;
         $display("FAIL rr_owner_only: v_re=%b v_mi=%0d want 1 0", v_re, v_mi);
      end
      tick();
      k_re = '0;
      k_mi = '0;
      wait_done(n);
      checks++;
      if (k_done !== 2'b01) begin
         errors++;
         $display("FAIL rr_done0: k_done=%b want 01", k_done);
      end
      for (int s = 0; s < 4; s++) begin
         exp = (s % 2 == 0) ? 2'b10 : 2'b01;
         wait_gnt(n);
         checks++;
         if (n != 1 || gnt !== exp) begin
            errors++;
            $display("FAIL rr_gnt%0d: gnt=%b n=%0d want %b 1", s, gnt, n, exp);
         end
         k_re = exp;
         tick();
         k_re = '0;
         wait_done(n);
         if (s == 3) req = '0;
         checks++;
         if (k_done !== exp || k_mo !== 8'd0 || k_po !== 2'd0) begin
            errors++;
            $display("FAIL rr_done%0d: k_done=%b k_mo=%0d k_po=%0d want %b 0 0",
                     s, k_done, k_mo, k_po, exp);
         end
      end
      req = '0;
   endtask

   task automatic test_insufficient();
      int n;
      req = 2'b10;
      wait_gnt(n);
      checks++;
      if (n != 1 || gnt !== 2'b10) begin
         errors++;
         $display("FAIL nf_gnt: gnt=%b n=%0d want 10 1", gnt, n);
      end
      k_mi[15:8] = 8'd5;
      k_sel[3:2] = 2'd2;
      #1;
      checks++;
      if (v_mi !== 8'd5 || v_sel !== 2'd2) begin
         errors++;
         $display("FAIL nf_fwd: v_mi=%0d v_sel=%0d want 5 2", v_mi, v_sel);
      end
      tick();
      checks++;
      if (v_mi !== 8'd0 || v_sel !== 2'd0) begin
         errors++;
         $display("FAIL nf_settle: v_mi=%0d v_sel=%0d want 0 0", v_mi, v_sel);
      end
      tick();
      k_mi[15:8] = 8'd15;
      #1;
      checks++;
      if (gnt !== 2'b10 || k_done !== 2'b00 || v_mi !== 8'd15) begin
         errors++;
         $display("FAIL nf_reserve: gnt=%b k_done=%b v_mi=%0d want 10 00 15",
                  gnt, k_done, v_mi);
      end
      tick();
      k_mi  = '0;
      k_sel = '0;
      req   = '0;
      tick();
      checks++;
      if (k_done !== 2'b10 || k_po !== 2'd2 || k_mo !== 8'd0) begin
         errors++;
         $display("FAIL nf_done: k_done=%b k_po=%0d k_mo=%0d want 10 2 0",
                  k_done, k_po, k_mo);
      end
   endtask

   task automatic test_timeout();
      int n;
      req = 2'b01;
      wait_gnt(n);
      checks++;
      if (n != 1 || gnt !== 2'b01) begin
         errors++;
         $display("FAIL to_gnt: gnt=%b n=%0d want 01 1", gnt, n);
      end
      k_mi[7:0] = 8'd7;
      tick();
      k_mi = '0;
      for (int i = 0; i < 15; i++) begin
         #1;
         checks++;
         if (v_re !== 1'b0 || gnt !== 2'b01) begin
            errors++;
            $display("FAIL to_idle%0d: v_re=%b gnt=%b want 0 01", i, v_re, gnt);
         end
         tick();
      end
      k_mi[7:0] = 8'd9;
      #1;
      checks++;
      if (v_re !== 1'b1 || v_mi !== 8'd0) begin
         errors++;
         $display("FAIL to_fire: v_re=%b v_mi=%0d want 1 0", v_re, v_mi);
      end
      tick();
      k_mi = '0;
      tick();
      checks++;
      if (k_done !== 2'b01 || k_po !== 2'd0 || k_mo !== 8'd7) begin
         errors++;
         $display("FAIL to_done: k_done=%b k_po=%0d k_mo=%0d want 01 0 7",
                  k_done, k_po, k_mo);
      end
      req = 2'b11;
      wait_gnt(n);
      checks++;
      if (n != 1 || gnt !== 2'b10) begin
         errors++;
         $display("FAIL to_ptr: gnt=%b n=%0d want 10 1", gnt, n);
      end
      k_re = 2'b10;
      tick();
      k_re = '0;
      req  = '0;
      wait_done(n);
      checks++;
      if (k_done !== 2'b10) begin
         errors++;
         $display("FAIL to_ptr_done: k_done=%b want 10", k_done);
      end
   endtask

   task automatic test_empty_reset();
      logic bad;
      int n;
      do_reset();
      test_config();
      session(0, 8'd10, 2'd1, bad);
      checks++;
      if (bad || k_done !== 2'b01 || k_po !== 2'd1 || k_mo !== 8'd0) begin
         errors++;
         $display("FAIL em_buy1: k_done=%b k_po=%0d k_mo=%0d want 01 1 0",
                  k_done, k_po, k_mo);
      end
      session(1, 8'd10, 2'd1, bad);
      checks++;
      if (bad || k_done !== 2'b10 || k_po !== 2'd1 || k_mo !== 8'd0) begin
         errors++;
         $display("FAIL em_buy2: k_done=%b k_po=%0d k_mo=%0d want 10 1 0",
                  k_done, k_po, k_mo);
      end
      session(0, 8'd20, 2'd2, bad);
      checks++;
      if (bad || k_done !== 2'b01 || k_po !== 2'd2 || k_mo !== 8'd0) begin
         errors++;
         $display("FAIL em_buy3: k_done=%b k_po=%0d k_mo=%0d want 01 2 0",
                  k_done, k_po, k_mo);
      end
      session(1, 8'd10, 2'd0, bad);
      checks++;
      if (bad || k_done !== 2'b10 || k_po !== 2'd0 || k_mo !== 8'd10) begin
         errors++;
         $display("FAIL em_refund: k_done=%b k_po=%0d k_mo=%0d want 10 0 10",
                  k_done, k_po, k_mo);
      end
      req = 2'b01;
      wait_gnt(n);
      k_mi[7:0] = 8'd3;
      #1;
      checks++;
      if (n != 1 || gnt !== 2'b01 || v_mi !== 8'd3) begin
         errors++;
         $display("FAIL rs_serve: gnt=%b v_mi=%0d n=%0d want 01 3 1", gnt, v_mi, n);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (gnt !== 2'b00 || k_done !== 2'b00 || k_mo !== 8'd0 || k_po !== 2'd0) begin
         errors++;
         $display("FAIL rs_out: gnt=%b k_done=%b k_mo=%0d k_po=%0d want 00 00 0 0",
                  gnt, k_done, k_mo, k_po);
      end
      checks++;
      if (run !== 1'b0 || v_rst !== 1'b1 || cfg_ready !== 1'b1 || v_mi !== 8'd0) begin
         errors++;
         $display("FAIL rs_ctl: run=%b v_rst=%b cfg_ready=%b v_mi=%0d want 0 1 1 0",
                  run, v_rst, cfg_ready, v_mi);
      end
      rst = 1'b0;
      repeat (3) tick();
      checks++;
      if (gnt !== 2'b00 || k_done !== 2'b00 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL rs_stay: gnt=%b k_done=%b cfg_ready=%b want 00 00 1",
                  gnt, k_done, cfg_ready);
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_config();
      test_purchase();
      test_round_robin();
      test_insufficient();
      test_timeout();
      test_empty_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
